// File: rtl/m_div_iter_if.sv
// Request/response bundle between decode, the iterative divider and writeback.
// The master side (decode + writeback) offers operations and drains results;
// the slave side is the divider itself.
interface m_div_iter_if #(
  parameter int XLEN = 32
) ();

  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid,
    output op,
    output rs1,
    output rs2,
    output kill,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  op,
    input  rs1,
    input  rs2,
    input  kill,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output busy
  );

endinterface

// File: rtl/m_div_iter.sv
// Multi-cycle radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Operands are reduced to magnitudes on accept, one quotient bit is produced
// per CALC cycle, and the signs are restored in a single FIX cycle.
// Division by zero and signed overflow follow the RISC-V rules; with
// FAST_SPEC set they are answered straight from IDLE without iterating.
module m_div_iter #(
  parameter int XLEN      = 32,
  parameter bit FAST_SPEC = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  m_div_iter_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Iteration state: partial remainder R, divisor magnitude D, and Z which
  // starts as the dividend magnitude and fills up with quotient bits.
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] div_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] result_q;
  logic [CW-1:0]   count;

  // Latched per-operation information needed when fixing up signs.
  logic [1:0] op_q;
  logic       neg1_q;
  logic       neg2_q;
  logic       div_zero_q;

  logic in_ready_c;
  logic accept;

  // Request-side decode.
  logic            in_signed;
  logic            rs1_neg;
  logic            rs2_neg;
  logic [XLEN-1:0] rs1_abs;
  logic [XLEN-1:0] rs2_abs;
  logic            in_div_zero;
  logic            in_ovf;
  logic            special;
  logic [XLEN-1:0] special_result;

  // One restoring step. The bit shifted out of R is kept so that divisors
  // above 2^(XLEN-1) still compare correctly against the shifted remainder.
  logic [XLEN:0]   rem_shift;
  logic [XLEN-1:0] quo_shift;
  logic            no_borrow;
  logic [XLEN-1:0] diff;

  // Sign restoration.
  logic            quo_negate;
  logic            rem_negate;
  logic [XLEN-1:0] fix_result;

  assign in_signed   = ~bus.op[0];
  assign rs1_neg     = in_signed & bus.rs1[XLEN-1];
  assign rs2_neg     = in_signed & bus.rs2[XLEN-1];
  assign rs1_abs     = rs1_neg ? (-bus.rs1) : bus.rs1;
  assign rs2_abs     = rs2_neg ? (-bus.rs2) : bus.rs2;
  assign in_div_zero = (bus.rs2 == '0);
  assign in_ovf      = in_signed & (bus.rs1 == MIN_VAL) & (bus.rs2 == '1);
  assign special     = FAST_SPEC & (in_div_zero | in_ovf);

  // Divide-by-zero is tested first so that MIN/0 is treated as a zero divisor.
  assign special_result = in_div_zero ? (bus.op[1] ? bus.rs1 : '1)
                                      : (bus.op[1] ? '0 : MIN_VAL);

  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign quo_shift = {quo_q[XLEN-2:0], 1'b0};
  assign no_borrow = (rem_shift >= {1'b0, div_q});
  assign diff      = rem_shift[XLEN-1:0] - div_q;

  // A zero divisor must yield an all-ones quotient regardless of the dividend
  // sign, so the quotient is never negated in that case. The remainder of a
  // zero divisor is |rs1| re-signed, which is rs1 itself.
  assign quo_negate = (neg1_q ^ neg2_q) & ~div_zero_q;
  assign rem_negate = neg1_q;
  assign fix_result = op_q[1] ? (rem_negate ? (-rem_q) : rem_q)
                              : (quo_negate ? (-quo_q) : quo_q);

  assign accept = bus.in_valid & in_ready_c;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.busy      = (state != IDLE);

  // State register; reset returns the controller to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and request-ready logic; kill overrides every transition.
  always_comb begin
    state_next = state;
    in_ready_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = ~bus.kill & ~reset;
        if (bus.in_valid & in_ready_c) begin
          state_next = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (count == '0) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (bus.kill) begin
      state_next = IDLE;
    end
  end

  // Datapath: latch operands on accept, iterate in CALC, load result in FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q      <= '0;
      div_q      <= '0;
      quo_q      <= '0;
      result_q   <= '0;
      count      <= '0;
      op_q       <= 2'b00;
      neg1_q     <= 1'b0;
      neg2_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (!bus.kill) begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q       <= bus.op;
            neg1_q     <= rs1_neg;
            neg2_q     <= rs2_neg;
            div_zero_q <= in_div_zero;
            quo_q      <= rs1_abs;
            div_q      <= rs2_abs;
            rem_q      <= '0;
            count      <= CW'(XLEN - 1);
            if (special) begin
              result_q <= special_result;
            end
          end
        end
        CALC: begin
          count <= count - 1'b1;
          if (no_borrow) begin
            rem_q <= diff;
            quo_q <= {quo_shift[XLEN-1:1], 1'b1};
          end else begin
            rem_q <= rem_shift[XLEN-1:0];
            quo_q <= quo_shift;
          end
        end
        FIX: begin
          result_q <= fix_result;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_div_iter.sv
// Self-checking bench for m_div_iter: a directed vector table on a 32-bit
// FAST_SPEC=1 instance and a FAST_SPEC=0 instance, hand-written handshake and
// kill sequences, and an 8-bit instance swept against a golden model.
module tb_m_div_iter;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  logic clk;
  logic reset;

  int total_cnt;
  int pass_cnt;

  m_div_iter_if #(.XLEN(32)) bus_f ();
  m_div_iter_if #(.XLEN(32)) bus_s ();
  m_div_iter_if #(.XLEN(8))  bus_8 ();

  m_div_iter #(.XLEN(32), .FAST_SPEC(1'b1)) dut_fast (.clk(clk), .reset(reset), .bus(bus_f));
  m_div_iter #(.XLEN(32), .FAST_SPEC(1'b0)) dut_slow (.clk(clk), .reset(reset), .bus(bus_s));
  m_div_iter #(.XLEN(8),  .FAST_SPEC(1'b1)) dut_8    (.clk(clk), .reset(reset), .bus(bus_8));

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  vec_t vecs[$];

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    total_cnt++;
    $display("[TB] FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic set_req(input int sel, input logic v, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    case (sel)
      0: begin bus_f.in_valid = v; bus_f.op = op; bus_f.rs1 = a; bus_f.rs2 = b; end
      1: begin bus_s.in_valid = v; bus_s.op = op; bus_s.rs1 = a; bus_s.rs2 = b; end
      default: begin bus_8.in_valid = v; bus_8.op = op; bus_8.rs1 = a[7:0]; bus_8.rs2 = b[7:0]; end
    endcase
  endtask

  task automatic set_out_ready(input int sel, input logic v);
    case (sel)
      0: bus_f.out_ready = v;
      1: bus_s.out_ready = v;
      default: bus_8.out_ready = v;
    endcase
  endtask

  function automatic logic get_ir(input int sel);
    case (sel)
      0: return bus_f.in_ready;
      1: return bus_s.in_ready;
      default: return bus_8.in_ready;
    endcase
  endfunction

  function automatic logic get_ov(input int sel);
    case (sel)
      0: return bus_f.out_valid;
      1: return bus_s.out_valid;
      default: return bus_8.out_valid;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0: return bus_f.busy;
      1: return bus_s.busy;
      default: return bus_8.busy;
    endcase
  endfunction

  function automatic logic [31:0] get_res(input int sel);
    case (sel)
      0: return bus_f.result;
      1: return bus_s.result;
      default: return {24'h0, bus_8.result};
    endcase
  endfunction

  // RISC-V reference for the 8-bit instance, written with native arithmetic.
  function automatic logic [7:0] gold8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int sa;
    int sb;
    int q;
    int r;
    if (b == 8'h00) return op[1] ? a : 8'hFF;
    if (!op[0]) begin
      if (a == 8'h80 && b == 8'hFF) return op[1] ? 8'h00 : 8'h80;
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = int'(a);
      sb = int'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return op[1] ? r[7:0] : q[7:0];
  endfunction

  function automatic bit special8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    return (b == 8'h00) || (!op[0] && a == 8'h80 && b == 8'hFF);
  endfunction

  function automatic vec_t mk(input string name, input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp, input bit special);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.exp = exp; v.special = special;
    return v;
  endfunction

  // Offer a request at a negedge and return at the negedge after it is accepted.
  task automatic start_op(input int sel, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, output bit ok);
    int guard;
    ok = 1'b0;
    set_req(sel, 1'b1, op, a, b);
    guard = 0;
    while (!get_ir(sel) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!get_ir(sel)) begin
      set_req(sel, 1'b0, op, a, b);
      note_timeout("accept");
      return;
    end
    @(posedge clk);
    @(negedge clk);
    set_req(sel, 1'b0, op, a, b);
    ok = 1'b1;
  endtask

  // Count cycles from accept until out_valid is seen; lat=1 on the first negedge after accept.
  task automatic wait_result(input int sel, output int lat, output bit ok);
    lat = 1;
    while (!get_ov(sel) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    ok = get_ov(sel);
    if (!ok) note_timeout("out_valid");
  endtask

  task automatic apply_stimulus(input int sel, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] res, output int lat);
    bit ok;
    res = '0;
    lat = -1;
    start_op(sel, op, a, b, ok);
    if (!ok) return;
    wait_result(sel, lat, ok);
    if (!ok) return;
    res = get_res(sel);
    set_out_ready(sel, 1'b1);
    @(negedge clk);
    set_out_ready(sel, 1'b0);
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    bit          ok;
    bit          seen;
    logic [7:0]  edges [8];
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [1:0]  rop;

    total_cnt = 0;
    pass_cnt  = 0;
    bus_f.kill = 1'b0; bus_s.kill = 1'b0; bus_8.kill = 1'b0;
    for (int s = 0; s < 3; s++) begin
      set_req(s, 1'b1, OP_DIVU, 32'd1, 32'd1);
      set_out_ready(s, 1'b0);
    end

    // Reset state, with a request held so that in_ready=0 under reset is visible.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check_output($sformatf("reset in_ready dut%0d", s), {31'b0, get_ir(s)}, 32'd0);
      check_output($sformatf("reset out_valid dut%0d", s), {31'b0, get_ov(s)}, 32'd0);
      check_output($sformatf("reset busy dut%0d", s), {31'b0, get_busy(s)}, 32'd0);
      check_output($sformatf("reset result dut%0d", s), get_res(s), 32'd0);
      set_req(s, 1'b0, OP_DIVU, 32'd0, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check_output($sformatf("idle in_ready dut%0d", s), {31'b0, get_ir(s)}, 32'd1);
    end

    vecs.push_back(mk("divu 100/7",      OP_DIVU, 32'd100,       32'd7,         32'd14,        1'b0));
    vecs.push_back(mk("remu 100/7",      OP_REMU, 32'd100,       32'd7,         32'd2,         1'b0));
    vecs.push_back(mk("div -7/2",        OP_DIV,  32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  1'b0));
    vecs.push_back(mk("rem -7/2",        OP_REM,  32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  1'b0));
    vecs.push_back(mk("rem 7/-2",        OP_REM,  32'd7,         32'hFFFFFFFE,  32'd1,         1'b0));
    vecs.push_back(mk("div -6/-3",       OP_DIV,  32'hFFFFFFFA,  32'hFFFFFFFD,  32'd2,         1'b0));
    vecs.push_back(mk("div min/2",       OP_DIV,  32'h80000000,  32'd2,         32'hC0000000,  1'b0));
    vecs.push_back(mk("divu min/-1",     OP_DIVU, 32'h80000000,  32'hFFFFFFFF,  32'd0,         1'b0));
    vecs.push_back(mk("remu min/-1",     OP_REMU, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b0));
    vecs.push_back(mk("divu fffe/ffff",  OP_DIVU, 32'hFFFFFFFE,  32'hFFFFFFFF,  32'd0,         1'b0));
    vecs.push_back(mk("divu ffff/8001",  OP_DIVU, 32'hFFFFFFFF,  32'h80000001,  32'd1,         1'b0));
    vecs.push_back(mk("remu ffff/8001",  OP_REMU, 32'hFFFFFFFF,  32'h80000001,  32'h7FFFFFFE,  1'b0));
    vecs.push_back(mk("divu ffff/1",     OP_DIVU, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  1'b0));
    vecs.push_back(mk("div 5/0",         OP_DIV,  32'd5,         32'd0,         32'hFFFFFFFF,  1'b1));
    vecs.push_back(mk("remu 5/0",        OP_REMU, 32'd5,         32'd0,         32'd5,         1'b1));
    vecs.push_back(mk("div -5/0",        OP_DIV,  32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  1'b1));
    vecs.push_back(mk("rem -5/0",        OP_REM,  32'hFFFFFFFB,  32'd0,         32'hFFFFFFFB,  1'b1));
    vecs.push_back(mk("div min/-1",      OP_DIV,  32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b1));
    vecs.push_back(mk("rem min/-1",      OP_REM,  32'h80000000,  32'hFFFFFFFF,  32'd0,         1'b1));

    // Vector table on both 32-bit instances; only FAST_SPEC=1 shortcuts the special cases.
    for (int s = 0; s < 2; s++) begin
      foreach (vecs[i]) begin
        apply_stimulus(s, vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
        check_output($sformatf("%s result dut%0d", vecs[i].name, s), res, vecs[i].exp);
        check_output($sformatf("%s latency dut%0d", vecs[i].name, s), lat,
                     (s == 0 && vecs[i].special) ? 32'd1 : 32'd34);
      end
    end

    // Result held in DONE while writeback stalls; a new request is offered meanwhile.
    start_op(0, OP_DIVU, 32'd100, 32'd7, ok);
    wait_result(0, lat, ok);
    set_req(0, 1'b1, OP_DIVU, 32'd50, 32'd5);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_output($sformatf("stall out_valid c%0d", c), {31'b0, bus_f.out_valid}, 32'd1);
      check_output($sformatf("stall result c%0d", c), bus_f.result, 32'd14);
      check_output($sformatf("stall in_ready c%0d", c), {31'b0, bus_f.in_ready}, 32'd0);
    end
    set_req(0, 1'b0, OP_DIVU, 32'd0, 32'd0);
    bus_f.out_ready = 1'b1;
    @(negedge clk);
    bus_f.out_ready = 1'b0;
    check_output("post-handshake busy", {31'b0, bus_f.busy}, 32'd0);
    check_output("post-handshake out_valid", {31'b0, bus_f.out_valid}, 32'd0);
    check_output("post-handshake in_ready", {31'b0, bus_f.in_ready}, 32'd1);

    // Kill ten cycles into CALC, then confirm nothing emerges and the unit recovers.
    start_op(0, OP_DIVU, 32'd1000, 32'd3, ok);
    repeat (9) @(negedge clk);
    bus_f.kill = 1'b1;
    @(negedge clk);
    bus_f.kill = 1'b0;
    check_output("kill calc busy", {31'b0, bus_f.busy}, 32'd0);
    check_output("kill calc out_valid", {31'b0, bus_f.out_valid}, 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus_f.out_valid) seen = 1'b1;
    end
    check_output("kill calc no result", {31'b0, seen}, 32'd0);
    apply_stimulus(0, OP_DIVU, 32'd9, 32'd3, res, lat);
    check_output("after kill divu 9/3", res, 32'd3);
    check_output("after kill latency", lat, 32'd34);

    // A request offered together with kill in IDLE must not be accepted.
    bus_f.kill = 1'b1;
    set_req(0, 1'b1, OP_DIVU, 32'd9, 32'd3);
    #1;
    check_output("kill idle in_ready", {31'b0, bus_f.in_ready}, 32'd0);
    @(negedge clk);
    bus_f.kill = 1'b0;
    set_req(0, 1'b0, OP_DIVU, 32'd0, 32'd0);
    check_output("kill idle busy", {31'b0, bus_f.busy}, 32'd0);
    @(negedge clk);
    check_output("kill idle out_valid", {31'b0, bus_f.out_valid}, 32'd0);

    // Kill while a result waits in DONE drops it.
    start_op(0, OP_DIVU, 32'd100, 32'd7, ok);
    wait_result(0, lat, ok);
    bus_f.kill = 1'b1;
    @(negedge clk);
    bus_f.kill = 1'b0;
    check_output("kill done out_valid", {31'b0, bus_f.out_valid}, 32'd0);
    check_output("kill done busy", {31'b0, bus_f.busy}, 32'd0);

    // 8-bit instance: every op over a grid of boundary operands, then random pairs.
    edges[0] = 8'h00; edges[1] = 8'h01; edges[2] = 8'h02; edges[3] = 8'h7F;
    edges[4] = 8'h80; edges[5] = 8'h81; edges[6] = 8'hFE; edges[7] = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        for (int o = 0; o < 4; o++) begin
          apply_stimulus(2, 2'(o), {24'h0, edges[i]}, {24'h0, edges[j]}, res, lat);
          check_output($sformatf("edge op%0d %h/%h", o, edges[i], edges[j]), res,
                       {24'h0, gold8(2'(o), edges[i], edges[j])});
          check_output($sformatf("edge lat op%0d %h/%h", o, edges[i], edges[j]), lat,
                       special8(2'(o), edges[i], edges[j]) ? 32'd1 : 32'd10);
        end
      end
    end
    for (int k = 0; k < 1200; k++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rop = 2'($urandom_range(0, 3));
      apply_stimulus(2, rop, {24'h0, ra}, {24'h0, rb}, res, lat);
      check_output($sformatf("rand op%0d %h/%h", rop, ra, rb), res, {24'h0, gold8(rop, ra, rb)});
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
